// File: rtl/apb_image_loader.sv
// APB master that streams one image's pixels into CatRecognizer, fires the start
// command, waits a fixed latency and reports the sampled classification.
module apb_image_loader #(
  parameter int unsigned Amba_Word       = 24,
  parameter int unsigned Amba_Addr_Depth = 13,
  parameter int unsigned PixelWidth      = 8,
  parameter int unsigned NumPixels       = 12288,
  parameter int unsigned ResultLatency   = 4150,
  parameter int unsigned CntWidth        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       img_start,
  input  logic                       exp_result,
  input  logic                       abort,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [PixelWidth-1:0]      pix_data,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic                       CatRecOut,
  output logic                       busy,
  output logic                       result_valid,
  output logic                       result,
  output logic                       match,
  output logic [CntWidth-1:0]        img_count,
  output logic [CntWidth-1:0]        err_count
);

  localparam int unsigned PPW      = Amba_Word / PixelWidth;
  localparam int unsigned NumWords = NumPixels / PPW;
  localparam int unsigned AW       = Amba_Addr_Depth;
  localparam int unsigned PCW      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned WCW      = (ResultLatency > 1) ? $clog2(ResultLatency) : 1;

  // Elaboration-time parameter sanity
  if (Amba_Word % PixelWidth != 0) begin : g_bad_word
    $error("Amba_Word must be a multiple of PixelWidth");
  end
  if (NumPixels % PPW != 0) begin : g_bad_pixels
    $error("NumPixels must be a multiple of pixels per word");
  end
  if (NumWords > (2 ** Amba_Addr_Depth) - 1) begin : g_bad_depth
    $error("image does not fit in the APB address space");
  end
  if (ResultLatency < 1) begin : g_bad_latency
    $error("ResultLatency must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE, CLR_S, CLR_A, FILL, WR_S, WR_A, GO_S, GO_A, WAIT, DONE
  } state_t;

  state_t               state, state_nx;
  logic [AW-1:0]        idx, idx_nx;
  logic [PCW-1:0]       pix_cnt, pix_cnt_nx;
  logic [WCW-1:0]       wait_cnt, wait_cnt_nx;
  logic [Amba_Word-1:0] word, word_nx, word_sh;
  logic                 exp_q, exp_nx;
  logic                 result_nx, match_nx;
  logic [CntWidth-1:0]  img_nx, err_nx;
  logic                 psel_nx, penable_nx, pwrite_nx;
  logic [AW-1:0]        paddr_nx;
  logic [Amba_Word-1:0] pwdata_nx;

  // First accepted pixel ends up in the MSBs after PPW shifts
  if (PPW > 1) begin : g_shift
    assign word_sh = {word[Amba_Word-PixelWidth-1:0], pix_data};
  end else begin : g_single
    assign word_sh = pix_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    pix_cnt_nx  = pix_cnt;
    wait_cnt_nx = wait_cnt;
    word_nx     = word;
    exp_nx      = exp_q;
    result_nx   = result;
    match_nx    = match;
    img_nx      = img_count;
    err_nx      = err_count;

    if (abort && state != IDLE) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (img_start && !abort) begin
          state_nx   = CLR_S;
          exp_nx     = exp_result;
          idx_nx     = '0;
          pix_cnt_nx = '0;
        end
        CLR_S: state_nx = CLR_A;
        CLR_A: state_nx = FILL;
        FILL: if (pix_valid) begin
          word_nx = word_sh;
          if (pix_cnt == PCW'(PPW - 1)) begin
            pix_cnt_nx = '0;
            state_nx   = WR_S;
          end else begin
            pix_cnt_nx = pix_cnt + PCW'(1);
          end
        end
        WR_S: state_nx = WR_A;
        WR_A: if (idx == AW'(NumWords - 1)) begin
          state_nx = GO_S;
        end else begin
          idx_nx   = idx + AW'(1);
          state_nx = FILL;
        end
        GO_S: state_nx = GO_A;
        GO_A: begin
          wait_cnt_nx = '0;
          state_nx    = WAIT;
        end
        WAIT: if (wait_cnt == WCW'(ResultLatency - 1)) begin
          state_nx  = DONE;
          result_nx = CatRecOut;
          match_nx  = (CatRecOut == exp_q);
          img_nx    = img_count + CntWidth'(1);
          if (CatRecOut != exp_q && err_count != '1) err_nx = err_count + CntWidth'(1);
        end else begin
          wait_cnt_nx = wait_cnt + WCW'(1);
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    // APB drive follows the state being entered; address/data hold when idle
    psel_nx    = 1'b0;
    penable_nx = 1'b0;
    pwrite_nx  = 1'b0;
    paddr_nx   = PADDR;
    pwdata_nx  = PWDATA;
    case (state_nx)
      CLR_S, CLR_A: begin
        psel_nx    = 1'b1;
        pwrite_nx  = 1'b1;
        penable_nx = (state_nx == CLR_A);
        paddr_nx   = '0;
        pwdata_nx  = '0;
      end
      WR_S, WR_A: begin
        psel_nx    = 1'b1;
        pwrite_nx  = 1'b1;
        penable_nx = (state_nx == WR_A);
        paddr_nx   = idx_nx + AW'(1);
        pwdata_nx  = word_nx;
      end
      GO_S, GO_A: begin
        psel_nx    = 1'b1;
        pwrite_nx  = 1'b1;
        penable_nx = (state_nx == GO_A);
        paddr_nx   = '0;
        pwdata_nx  = Amba_Word'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      pix_cnt      <= '0;
      wait_cnt     <= '0;
      word         <= '0;
      exp_q        <= 1'b0;
      result       <= 1'b0;
      match        <= 1'b0;
      img_count    <= '0;
      err_count    <= '0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      pix_ready    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      idx          <= idx_nx;
      pix_cnt      <= pix_cnt_nx;
      wait_cnt     <= wait_cnt_nx;
      word         <= word_nx;
      exp_q        <= exp_nx;
      result       <= result_nx;
      match        <= match_nx;
      img_count    <= img_nx;
      err_count    <= err_nx;
      PSEL         <= psel_nx;
      PENABLE      <= penable_nx;
      PWRITE       <= pwrite_nx;
      PADDR        <= paddr_nx;
      PWDATA       <= pwdata_nx;
      pix_ready    <= (state_nx == FILL);
      busy         <= (state_nx != IDLE);
      result_valid <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_apb_image_loader.sv
// Directed bench for apb_image_loader: scoreboarded APB writes and results
// with a small 12-pixel, 4-word image.
module tb_apb_image_loader;

  localparam int unsigned NPIX = 12;
  localparam int unsigned NWRD = 4;

  typedef struct packed {
    logic [12:0] addr;
    logic [23:0] data;
  } apb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        img_start, exp_result, abort, pix_valid, pix_ready;
  logic [7:0]  pix_data;
  logic        PSEL, PENABLE, PWRITE;
  logic [12:0] PADDR;
  logic [23:0] PWDATA;
  logic        CatRecOut, busy, result_valid, result, match;
  logic [15:0] img_count, err_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_img  = 0;
  int exp_err  = 0;

  apb_t       apb_q[$];
  logic [1:0] res_q[$];

  apb_image_loader #(
    .Amba_Word(24), .Amba_Addr_Depth(13), .PixelWidth(8),
    .NumPixels(NPIX), .ResultLatency(5), .CntWidth(16)
  ) dut (
    .clk(clk), .rst(rst), .img_start(img_start), .exp_result(exp_result),
    .abort(abort), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .CatRecOut(CatRecOut), .busy(busy), .result_valid(result_valid),
    .result(result), .match(match), .img_count(img_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_psel"}, PSEL, 0);
    chk({tag, "_penable"}, PENABLE, 0);
    chk({tag, "_pwrite"}, PWRITE, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_paddr"}, PADDR, 0);
    chk({tag, "_pwdata"}, PWDATA, 0);
    chk({tag, "_img_count"}, img_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  // APB monitor: every access phase must follow a matching setup phase
  logic        prev_setup = 1'b0;
  logic [12:0] prev_addr  = '0;
  logic [23:0] prev_data  = '0;
  always @(negedge clk) begin
    apb_t e;
    if (PSEL) chk("pix_ready_during_apb", pix_ready, 0);
    if (PSEL && PENABLE) begin
      chk("apb_setup_before_access", {prev_setup, prev_addr, prev_data}, {1'b1, PADDR, PWDATA});
      chk("apb_pwrite", PWRITE, 1);
      if (apb_q.size() == 0) begin
        chk("apb_unexpected_write", {PADDR, PWDATA}, 0);
      end else begin
        e = apb_q.pop_front();
        chk("apb_addr", PADDR, e.addr);
        chk("apb_data", PWDATA, e.data);
      end
    end
    prev_setup = PSEL && !PENABLE;
    prev_addr  = PADDR;
    prev_data  = PWDATA;
  end

  // Result monitor
  always @(negedge clk) begin
    logic [1:0] r;
    if (result_valid) begin
      if (res_q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        r = res_q.pop_front();
        chk("result", result, r[1]);
        chk("match", match, r[0]);
      end
    end
  end

  task automatic run_image(input bit expv, input bit cat, input bit gaps,
                           input int abort_after, input bit extra_start,
                           input bit rst_wait, output int lat);
    int   sent, cyc, go_cnt, words;
    bit   done, go_seen;
    apb_t e;
    words = (abort_after > 0) ? abort_after / 3 : NWRD;
    e.addr = '0; e.data = '0;
    apb_q.push_back(e);
    for (int w = 0; w < words; w++) begin
      e.addr = 13'(w + 1);
      e.data = {8'(3*w + 1), 8'(3*w + 2), 8'(3*w + 3)};
      apb_q.push_back(e);
    end
    if (abort_after == 0) begin
      e.addr = '0; e.data = 24'd1;
      apb_q.push_back(e);
    end
    if (abort_after == 0 && !rst_wait) begin
      res_q.push_back({cat, cat == expv});
      exp_img++;
      if (cat != expv && exp_err != 16'hFFFF) exp_err++;
    end

    @(negedge clk);
    img_start = 1'b1; exp_result = expv; CatRecOut = cat;
    @(negedge clk);
    img_start = 1'b0;
    sent = 0; cyc = 0; lat = 0; go_cnt = 0; done = 0; go_seen = 0;
    while (!done && cyc < 400) begin
      if (PSEL && PENABLE && PADDR == 13'd0 && PWDATA == 24'd1) go_seen = 1;
      else if (go_seen) go_cnt++;
      if (busy) lat++;
      if (result_valid) begin
        done = 1;
      end else if (abort_after > 0 && sent == abort_after) begin
        abort = 1'b1; pix_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_psel", PSEL, 0);
        chk("abort_pix_ready", pix_ready, 0);
        repeat (20) @(negedge clk);
        chk("abort_pending_writes", apb_q.size(), 0);
        done = 1;
      end else if (rst_wait && go_cnt == 2) begin
        pix_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_values("rst_in_wait");
        @(negedge clk);
        rst = 1'b0;
        exp_img = 0; exp_err = 0;
        done = 1;
      end else begin
        img_start = extra_start && (cyc == 4);
        pix_valid = (sent < NPIX) && (!gaps || ($urandom_range(0, 2) != 0));
        pix_data  = 8'(sent + 1);
        if (pix_valid && pix_ready) sent++;
        @(negedge clk);
      end
      cyc++;
    end
    img_start = 1'b0; pix_valid = 1'b0;
    if (!done) chk("image_timeout", 0, 1);
  endtask

  task automatic after_image(input string tag);
    @(negedge clk);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_img_count"}, img_count, 16'(exp_img));
    chk({tag, "_err_count"}, err_count, 16'(exp_err));
    chk({tag, "_apb_q_empty"}, apb_q.size(), 0);
    chk({tag, "_res_q_empty"}, res_q.size(), 0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; img_start = 0; exp_result = 0; abort = 0;
    pix_valid = 0; pix_data = '0; CatRecOut = 0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;

    run_image(1, 1, 0, 0, 0, 0, lat);
    chk("latency_continuous", lat, 30);
    after_image("img_match");

    run_image(1, 0, 0, 0, 0, 0, lat);
    chk("latency_mismatch", lat, 30);
    after_image("img_mismatch");

    run_image(0, 0, 1, 0, 0, 0, lat);
    after_image("img_gaps");

    run_image(1, 1, 0, 5, 0, 0, lat);
    after_image("img_abort");

    run_image(1, 1, 0, 0, 0, 0, lat);
    chk("latency_restart", lat, 30);
    after_image("img_restart");

    run_image(0, 1, 0, 0, 1, 0, lat);
    after_image("img_extra_start");
    repeat (40) @(negedge clk);
    chk("extra_start_idle", busy, 0);
    chk("extra_start_one_image", img_count, 16'(exp_img));

    run_image(1, 1, 0, 0, 0, 1, lat);
    after_image("img_rst_wait");

    run_image(0, 1, 1, 0, 0, 0, lat);
    after_image("img_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
